// File: rtl/subtree_sched_pkg.sv
// Shared definitions for the subtree round-robin scheduler: FSM state
// encoding and the default requester count / hold limit.
package subtree_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    localparam int SCHED_N_REQ    = 5;
    localparam int SCHED_MAX_HOLD = 4;

endpackage : subtree_sched_pkg

// File: rtl/subtree_rr_scheduler_rr_pick.sv
// Rotating-priority picker: scans req_i starting at ptr_i, wrapping at
// N_REQ, and reports the first requester found as a one-hot vector and index.
module rr_pick #(
    parameter int N_REQ = 5,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk the candidates in priority order from ptr_i; the first hit wins.
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
        if (found_o) begin
            winner_o[idx_o] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/subtree_rr_scheduler.sv
// Round-robin owner scheduler for the leaf children of a subtree node.
// One owner at a time, bounded hold time, priority rotates past the last
// owner on every release, with one dead IDLE cycle between grants.
module subtree_rr_scheduler
    import subtree_sched_pkg::*;
#(
    parameter int N_REQ    = SCHED_N_REQ,
    parameter int MAX_HOLD = SCHED_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     preempt
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    sched_state_e      state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              preempt_q, preempt_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;

    logic              own_done;
    logic              own_req;
    logic              expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (pick_grant),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Next-state logic: arbitrate while IDLE, count and watch for release while BUSY.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        own_done  = done[idx_q];
        own_req   = req[idx_q];
        expired   = (hold_q == HOLD_LAST);
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_grant;
                    idx_d   = pick_idx;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (own_done || !own_req || expired) begin
                    grant_d   = '0;
                    idx_d     = '0;
                    hold_d    = '0;
                    state_d   = IDLE;
                    ptr_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    preempt_d = expired && !own_done && own_req;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State register with synchronous reset back to IDLE and pointer 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;
    assign preempt     = preempt_q;

endmodule : subtree_rr_scheduler

// File: tb/tb_subtree_rr_scheduler.sv
// Self-checking bench for subtree_rr_scheduler: directed scenarios with
// hand-computed expectations plus a long randomized run, all compared each
// cycle against an ownership-level model of the scheduler.
module tb_subtree_rr_scheduler;

    localparam int N  = 5;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_idx;
    logic         preempt;

    int errors = 0;
    int checks = 0;

    // Model: who owns the resource, how many grant cycles it has had,
    // where the next search starts, and whether the last release was a timeout.
    int mOwner   = -1;
    int mHeld    = 0;
    int mPtr     = 0;
    bit mPreempt = 1'b0;

    always #5 clk = ~clk;

    subtree_rr_scheduler #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt)
    );

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelStep(input bit r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        int o;
        if (r) begin
            mOwner   = -1;
            mHeld    = 0;
            mPtr     = 0;
            mPreempt = 1'b0;
        end else if (mOwner < 0) begin
            mPreempt = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mPtr + k) % N;
                if (rq[c]) begin
                    mOwner = c;
                    mHeld  = 1;
                    break;
                end
            end
        end else begin
            o = mOwner;
            if (dn[o] || !rq[o] || mHeld == MH) begin
                mPreempt = (mHeld == MH) && !dn[o] && rq[o];
                mOwner   = -1;
                mHeld    = 0;
                mPtr     = (o + 1) % N;
            end else begin
                mPreempt = 1'b0;
                mHeld    = mHeld + 1;
            end
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        logic [N-1:0] eg;
        eg = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
        checks++;
        if (grant !== eg) begin
            errors++;
            $display("[TB] FAIL grant at %0t: got %b expected %b", $time, grant, eg);
        end
        checkValue("grant_valid", int'(grant_valid), (mOwner >= 0) ? 1 : 0);
        checkValue("grant_idx", int'(grant_idx), (mOwner >= 0) ? mOwner : 0);
        checkValue("preempt", int'(preempt), int'(mPreempt));
    endtask

    // Drive one cycle of inputs on the falling edge, then check after the rising edge.
    task automatic applyStimulus(input bit r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        @(posedge clk);
        modelStep(r, rq, dn);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b1, '0, '0);
    endtask

    initial begin
        int order[$];
        int pc;
        bit prevValid;
        logic [N-1:0] rq;
        logic [N-1:0] dn;

        // Reset state.
        doReset();
        checkValue("reset_grant", int'(grant), 0);
        checkValue("reset_idx", int'(grant_idx), 0);

        // Single requester: four grant cycles, preempt, dead cycle, re-grant.
        applyStimulus(1'b0, 5'b00100, '0);
        checkValue("single_grant", int'(grant), 5'b00100);
        checkValue("single_idx", int'(grant_idx), 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00100, '0);
        checkValue("single_held4", int'(grant), 5'b00100);
        applyStimulus(1'b0, 5'b00100, '0);
        checkValue("single_dead", int'(grant), 0);
        checkValue("single_preempt", int'(preempt), 1);
        applyStimulus(1'b0, 5'b00100, '0);
        checkValue("single_regrant", int'(grant), 5'b00100);
        checkValue("single_preempt_end", int'(preempt), 0);

        // Everybody requesting: order 0,1,2,3,4,0 with five preempts.
        doReset();
        pc = 0;
        prevValid = 1'b0;
        for (int i = 0; i < 26; i++) begin
            applyStimulus(1'b0, 5'b11111, '0);
            if (grant_valid && !prevValid) order.push_back(int'(grant_idx));
            prevValid = grant_valid;
            if (preempt) pc++;
        end
        checkValue("all_grants", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            checkValue("all_order", order[i], i % 5);
        end
        checkValue("all_preempts", pc, 5);

        // Early release by owner 3, next owner is 4.
        doReset();
        applyStimulus(1'b0, 5'b01000, '0);
        applyStimulus(1'b0, 5'b11001, '0);
        applyStimulus(1'b0, 5'b11001, 5'b01000);
        checkValue("early_drop", int'(grant), 0);
        checkValue("early_no_preempt", int'(preempt), 0);
        applyStimulus(1'b0, 5'b11001, '0);
        checkValue("early_next", int'(grant_idx), 4);

        // Non-owner done ignored; expiry still preempts.
        doReset();
        applyStimulus(1'b0, 5'b00010, 5'b00100);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b00010, 5'b00100);
        checkValue("nonowner_hold", int'(grant), 5'b00010);
        applyStimulus(1'b0, 5'b00010, 5'b00100);
        checkValue("nonowner_preempt", int'(preempt), 1);

        // Done together with expiry: normal release.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'b00001, '0);
        applyStimulus(1'b0, 5'b00001, 5'b00001);
        checkValue("done_expiry_grant", int'(grant), 0);
        checkValue("done_expiry_preempt", int'(preempt), 0);

        // Reset during a grant, then pointer back at 0.
        doReset();
        applyStimulus(1'b0, 5'b00100, '0);
        applyStimulus(1'b0, 5'b00100, '0);
        applyStimulus(1'b1, 5'b00100, '0);
        checkValue("midreset_grant", int'(grant), 0);
        checkValue("midreset_idx", int'(grant_idx), 0);
        applyStimulus(1'b0, 5'b00110, '0);
        checkValue("midreset_regrant", int'(grant), 5'b00010);

        // Randomized traffic against the model.
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            dn = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            applyStimulus($urandom_range(0, 199) == 0, rq, dn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_subtree_rr_scheduler
